// File: rtl/layer_addr_seq.sv
// Purpose : per-layer beat/phase sequencer for the feature-map address generator (3x3, 1x1, maxpool).
// Latency : phase outputs are registered (one cycle after start); pass_last is combinational on the accepted beat.
// Backpr. : a beat advances only when beat_ready=1 and stall_4k=0; any other cycle holds all state.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   ap_start, ap_done   : host start request / done acknowledge
//   mode                : 01 = 1x1, 10 = 3x3, 11 = maxpool, 00 = illegal
//   row_beats           : first-row beats per 3x3 pass
//   body_beats          : reuse beats per 3x3 pass, or beats per 1x1/maxpool pass
//   ofm_passes          : number of output-channel passes (ignored for maxpool)
//   beat_ready, stall_4k: downstream FIFO space / AXI 4 KB boundary hold
//   one_one_conv, maxpool, three_three_row_1, three_three_reuse : phase indicators
//   pass_last           : accepted last beat of a pass
//   layer_done          : layer finished, waiting for ap_done
//   cfg_err             : one-cycle pulse after a rejected start
//   pass_idx            : current output-channel pass
// Optional: define LAYER_ADDR_SEQ_PERF_EN to add stall_cycles / beat_total counters.
module layer_addr_seq #(
    parameter int CNT_W = 20,
    parameter int CH_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ap_start,
    input  logic             ap_done,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] row_beats,
    input  logic [CNT_W-1:0] body_beats,
    input  logic [CH_W-1:0]  ofm_passes,
    input  logic             beat_ready,
    input  logic             stall_4k,
    output logic             one_one_conv,
    output logic             maxpool,
    output logic             three_three_row_1,
    output logic             three_three_reuse,
    output logic             pass_last,
    output logic             layer_done,
    output logic             cfg_err,
    output logic [CH_W-1:0]  pass_idx
`ifdef LAYER_ADDR_SEQ_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      beat_total
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW1 = 3'd1,
        S_BODY = 3'd2,
        S_FLAT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] MODE_1X1  = 2'b01;
    localparam logic [1:0] MODE_3X3  = 2'b10;
    localparam logic [1:0] MODE_POOL = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] row_beats_q, row_beats_d;
    logic [CNT_W-1:0] body_beats_q, body_beats_d;
    logic [CH_W-1:0]  ofm_passes_q, ofm_passes_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CH_W-1:0]  pass_idx_q, pass_idx_d;
    logic             cfg_err_q, cfg_err_d;
    logic             pass_last_c;

    logic active;
    logic beat_acc;
    logic start_req;
    logic start_bad;
    logic row_last;
    logic body_last;
    logic final_pass;

    assign active    = (state_q == S_ROW1) || (state_q == S_BODY) || (state_q == S_FLAT);
    // Reset gates acceptance so an aborted layer never emits a pass_last pulse.
    assign beat_acc  = active && beat_ready && !stall_4k && !rst;
    assign start_req = (state_q == S_IDLE) && ap_start && !ap_done;

    // Validation looks at the live inputs, the same values being latched this cycle.
    assign start_bad = (mode == 2'b00)
                    || (body_beats == '0)
                    || ((mode != MODE_POOL) && (ofm_passes == '0))
                    || ((mode == MODE_3X3) && (row_beats == '0));

    // Latched counts are never zero in an active state, so count-1 cannot wrap.
    assign row_last   = (beat_cnt_q == row_beats_q - CNT_W'(1));
    assign body_last  = (beat_cnt_q == body_beats_q - CNT_W'(1));
    assign final_pass = (mode_q == MODE_POOL) || (pass_idx_q == ofm_passes_q - CH_W'(1));

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        row_beats_d  = row_beats_q;
        body_beats_d = body_beats_q;
        ofm_passes_d = ofm_passes_q;
        beat_cnt_d   = beat_cnt_q;
        pass_idx_d   = pass_idx_q;
        cfg_err_d    = 1'b0;
        pass_last_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    mode_d       = mode;
                    row_beats_d  = row_beats;
                    body_beats_d = body_beats;
                    ofm_passes_d = ofm_passes;
                    beat_cnt_d   = '0;
                    pass_idx_d   = '0;
                    if (start_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = (mode == MODE_3X3) ? S_ROW1 : S_FLAT;
                    end
                end
            end
            S_ROW1: begin
                if (beat_acc) begin
                    if (row_last) begin
                        beat_cnt_d = '0;
                        state_d    = S_BODY;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_BODY, S_FLAT: begin
                if (beat_acc) begin
                    if (body_last) begin
                        pass_last_c = 1'b1;
                        beat_cnt_d  = '0;
                        if (final_pass) begin
                            state_d = S_DONE;
                        end else begin
                            pass_idx_d = pass_idx_q + CH_W'(1);
                            // 3x3 re-reads its first row every pass; 1x1 stays flat.
                            state_d    = (state_q == S_BODY) ? S_ROW1 : S_FLAT;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (ap_done && !ap_start) begin
                    state_d    = S_IDLE;
                    beat_cnt_d = '0;
                    pass_idx_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            row_beats_q  <= '0;
            body_beats_q <= '0;
            ofm_passes_q <= '0;
            beat_cnt_q   <= '0;
            pass_idx_q   <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            row_beats_q  <= row_beats_d;
            body_beats_q <= body_beats_d;
            ofm_passes_q <= ofm_passes_d;
            beat_cnt_q   <= beat_cnt_d;
            pass_idx_q   <= pass_idx_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

`ifdef LAYER_ADDR_SEQ_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] beat_total_q;

    always_ff @(posedge clk) begin
        if (rst || (start_req && !start_bad)) begin
            stall_cycles_q <= '0;
            beat_total_q   <= '0;
        end else if (active) begin
            if (beat_acc) begin
                if (beat_total_q != '1) beat_total_q <= beat_total_q + 32'd1;
            end else begin
                if (stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign beat_total   = beat_total_q;
`endif

    assign one_one_conv      = (state_q == S_FLAT) && (mode_q == MODE_1X1);
    assign maxpool           = (state_q == S_FLAT) && (mode_q == MODE_POOL);
    assign three_three_row_1 = (state_q == S_ROW1);
    assign three_three_reuse = (state_q == S_BODY);
    assign pass_last         = pass_last_c;
    assign layer_done        = (state_q == S_DONE);
    assign cfg_err           = cfg_err_q;
    assign pass_idx          = pass_idx_q;

endmodule

// File: tb/tb_layer_addr_seq.sv
// Bench for layer_addr_seq: a beat-schedule model (a queue of expected beats built at
// each accepted start) is compared against the DUT every cycle, plus a table of layer
// configurations and hand-written corner sequences.
module tb_layer_addr_seq;
    localparam int CNT_W = 20;
    localparam int CH_W  = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             ap_start;
    logic             ap_done;
    logic [1:0]       mode;
    logic [CNT_W-1:0] row_beats;
    logic [CNT_W-1:0] body_beats;
    logic [CH_W-1:0]  ofm_passes;
    logic             beat_ready;
    logic             stall_4k;
    logic             one_one_conv, maxpool, three_three_row_1, three_three_reuse;
    logic             pass_last, layer_done, cfg_err;
    logic [CH_W-1:0]  pass_idx;
`ifdef LAYER_ADDR_SEQ_PERF_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      beat_total;
`endif

    always #5 clk = ~clk;

    layer_addr_seq #(.CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .ap_start          (ap_start),
        .ap_done           (ap_done),
        .mode              (mode),
        .row_beats         (row_beats),
        .body_beats        (body_beats),
        .ofm_passes        (ofm_passes),
        .beat_ready        (beat_ready),
        .stall_4k          (stall_4k),
        .one_one_conv      (one_one_conv),
        .maxpool           (maxpool),
        .three_three_row_1 (three_three_row_1),
        .three_three_reuse (three_three_reuse),
        .pass_last         (pass_last),
        .layer_done        (layer_done),
        .cfg_err           (cfg_err),
        .pass_idx          (pass_idx)
`ifdef LAYER_ADDR_SEQ_PERF_EN
        ,
        .stall_cycles      (stall_cycles),
        .beat_total        (beat_total)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // ph: 1 = 3x3 first row, 2 = 3x3 reuse, 3 = 1x1, 4 = maxpool
    typedef struct {
        int ph;
        int pidx;
        bit last;
    } beat_t;

    beat_t q[$];
    bit    m_done      = 0;
    int    m_pidx_done = 0;
    bit    m_err       = 0;
    int    m_stall     = 0;
    int    m_beats     = 0;

    // Observations taken from the DUT, used by table/scenario checks.
    logic [6:0] obs;
    int         n_beats, n_last, n_err;

    function automatic bit cfg_bad();
        return (mode == 2'b00) || (body_beats == 0) ||
               ((mode != 2'b11) && (ofm_passes == 0)) ||
               ((mode == 2'b10) && (row_beats == 0));
    endfunction

    function automatic void build();
        int np;
        np = (mode == 2'b11) ? 1 : int'(ofm_passes);
        for (int p = 0; p < np; p++) begin
            if (mode == 2'b10)
                for (int i = 0; i < int'(row_beats); i++) q.push_back('{1, p, 1'b0});
            for (int i = 0; i < int'(body_beats); i++)
                q.push_back('{(mode == 2'b10) ? 2 : (mode == 2'b01) ? 3 : 4, p, (i == int'(body_beats) - 1)});
        end
        m_stall = 0;
        m_beats = 0;
    endfunction

    // One clock cycle: drive, compare at negedge, advance the model after the edge.
    task automatic step(input bit r, input bit st, input bit dn, input bit rdy, input bit stl);
        bit              acc;
        logic [6:0]      ef;
        logic [CH_W-1:0] ep;
        rst = r; ap_start = st; ap_done = dn; beat_ready = rdy; stall_4k = stl;
        @(negedge clk);
        acc = (q.size() > 0) && rdy && !stl && !r;
        ef  = '0;
        ep  = '0;
        if (q.size() > 0) begin
            ef[6] = (q[0].ph == 3);
            ef[5] = (q[0].ph == 4);
            ef[4] = (q[0].ph == 1);
            ef[3] = (q[0].ph == 2);
            ef[2] = acc && q[0].last;
            ep    = CH_W'(q[0].pidx);
        end else if (m_done) begin
            ef[1] = 1'b1;
            ep    = CH_W'(m_pidx_done);
        end
        ef[0] = m_err;
        obs = {one_one_conv, maxpool, three_three_row_1, three_three_reuse, pass_last, layer_done, cfg_err};
        chk("cycle_outputs", 64'({obs, pass_idx}), 64'({ef, ep}));
`ifdef LAYER_ADDR_SEQ_PERF_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        chk("beat_total", 64'(beat_total), 64'(m_beats));
`endif
        if ((obs[6:3] != 0) && rdy && !stl && !r) n_beats++;
        if (obs[2]) n_last++;
        if (obs[0]) n_err++;
        @(posedge clk);
        #1;
        m_err = 0;
        if (r) begin
            q.delete();
            m_done = 0; m_pidx_done = 0; m_stall = 0; m_beats = 0;
        end else if (q.size() > 0) begin
            if (acc) begin
                m_beats++;
                if (q.size() == 1) begin
                    m_done      = 1;
                    m_pidx_done = q[0].pidx;
                end
                void'(q.pop_front());
            end else begin
                m_stall++;
            end
        end else if (m_done) begin
            if (dn && !st) m_done = 0;
        end else if (st && !dn) begin
            if (cfg_bad()) m_err = 1;
            else build();
        end
    endtask

    task automatic set_cfg(input logic [1:0] md, input int rb, input int bb, input int np);
        mode = md; row_beats = CNT_W'(rb); body_beats = CNT_W'(bb); ofm_passes = CH_W'(np);
    endtask

    // Start a layer, drain it with beat_ready=1, then acknowledge.
    task automatic run_layer();
        int c;
        n_beats = 0; n_last = 0; n_err = 0;
        step(0, 1, 0, 1, 0);
        c = 0;
        while ((q.size() > 0) && (c < 500)) begin
            step(0, 0, 0, 1, 0);
            c++;
        end
        chk("layer_drained", 64'(q.size()), 64'd0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
    endtask

    typedef struct {
        logic [1:0] md;
        int         rb, bb, np;
        int         err, beats, lasts;
    } vec_t;

    vec_t vt[9];
    int   pl[$];
    int   first_done;
    int   injected;

    initial begin
        vt[0] = '{2'b10, 4, 6, 2, 0, 20, 2};
        vt[1] = '{2'b01, 0, 8, 3, 0, 24, 3};
        vt[2] = '{2'b11, 0, 1, 7, 0, 1, 1};
        vt[3] = '{2'b00, 4, 6, 2, 1, 0, 0};
        vt[4] = '{2'b01, 4, 6, 0, 1, 0, 0};
        vt[5] = '{2'b10, 0, 6, 2, 1, 0, 0};
        vt[6] = '{2'b11, 0, 0, 1, 1, 0, 0};
        vt[7] = '{2'b10, 1, 1, 1, 0, 2, 1};
        vt[8] = '{2'b11, 0, 3, 0, 0, 3, 1};

        rst = 1; ap_start = 0; ap_done = 0; beat_ready = 0; stall_4k = 0;
        set_cfg(2'b00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset_outputs", 64'({obs, pass_idx}), 64'd0);

        // ---- table of configurations ----
        for (int i = 0; i < 9; i++) begin
            set_cfg(vt[i].md, vt[i].rb, vt[i].bb, vt[i].np);
            run_layer();
            chk($sformatf("vec%0d_cfg_err", i), 64'(n_err), 64'(vt[i].err));
            chk($sformatf("vec%0d_beats", i), 64'(n_beats), 64'(vt[i].beats));
            chk($sformatf("vec%0d_pass_last", i), 64'(n_last), 64'(vt[i].lasts));
        end

        // ---- exact 3x3 timing ----
        set_cfg(2'b10, 4, 6, 2);
        pl.delete();
        first_done = -1;
        step(0, 1, 0, 1, 0);
        set_cfg(2'b01, 1, 1, 1);   // must be ignored after latching
        for (int c = 1; c <= 22; c++) begin
            step(0, 0, 0, 1, 0);
            if (obs[2]) pl.push_back(c);
            if (obs[1] && first_done < 0) first_done = c;
        end
        chk("t33_last_count", 64'(pl.size()), 64'd2);
        chk("t33_last_first", 64'((pl.size() > 0) ? pl[0] : -1), 64'd10);
        chk("t33_last_second", 64'((pl.size() > 1) ? pl[1] : -1), 64'd20);
        chk("t33_done_cycle", 64'(first_done), 64'd21);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);

        // ---- same layer with 4 KB stalls and a 5-cycle backpressure window ----
        set_cfg(2'b10, 4, 6, 2);
        n_beats = 0; n_last = 0; injected = 0;
        step(0, 1, 0, 1, 0);
        for (int c = 1; (c < 200) && (q.size() > 0); c++) begin
            if ((c % 3 == 2) || ((c >= 7) && (c <= 11))) injected++;
            step(0, 0, 0, !((c >= 7) && (c <= 11)), (c % 3 == 2));
        end
        chk("stall_drained", 64'(q.size()), 64'd0);
        chk("stall_beats", 64'(n_beats), 64'd20);
        chk("stall_pass_last", 64'(n_last), 64'd2);
`ifdef LAYER_ADDR_SEQ_PERF_EN
        chk("stall_total", 64'(stall_cycles), 64'(injected));
        chk("beat_total_20", 64'(beat_total), 64'd20);
`endif
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);

        // ---- mid-layer reset, then a clean rerun ----
        set_cfg(2'b01, 0, 8, 3);
        step(0, 1, 0, 1, 0);
        for (int c = 0; c < 13; c++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("midrst_no_last", 64'(obs[2]), 64'd0);
        step(0, 0, 0, 1, 0);
        chk("midrst_outputs", 64'({obs, pass_idx}), 64'd0);
        run_layer();
        chk("rerun_beats", 64'(n_beats), 64'd24);
        chk("rerun_pass_last", 64'(n_last), 64'd3);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 4000; c++) begin
            set_cfg(2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3));
            step($urandom_range(0, 599) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_addr_seq.md
LAYER_ADDR_SEQ -- requirements
Module: layer_addr_seq

Interface
- REQ-001 The module SHALL use a single clock and a synchronous, active-high reset: `clk`, `rst`.
- REQ-002 Parameter `CNT_W`, default 20: width of the beat counters and beat-count inputs.
- REQ-003 Parameter `CH_W`, default 12: width of the pass counter and `ofm_passes`.
- REQ-004 Port `clk`, input, 1 bit: clock; every register updates on its rising edge.
- REQ-005 Port `rst`, input, 1 bit: synchronous active-high reset.
- REQ-006 Port `ap_start`, input, 1 bit: layer start request.
- REQ-007 Port `ap_done`, input, 1 bit: host done acknowledge.
- REQ-008 Port `mode`, input, 2 bits: 01 = 1x1 conv, 10 = 3x3 conv, 11 = maxpool, 00 = illegal.
- REQ-009 Port `row_beats`, input, `CNT_W` bits: first-row beats per 3x3 pass.
- REQ-010 Port `body_beats`, input, `CNT_W` bits: reuse beats per 3x3 pass, or beats per 1x1/maxpool pass.
- REQ-011 Port `ofm_passes`, input, `CH_W` bits: number of output-channel passes.
- REQ-012 Port `beat_ready`, input, 1 bit: downstream FIFO not full.
- REQ-013 Port `stall_4k`, input, 1 bit: AXI 4 KB boundary hold.
- REQ-014 Port `one_one_conv`, output, 1 bit: high while in `S_FLAT` with latched mode 01.
- REQ-015 Port `maxpool`, output, 1 bit: high while in `S_FLAT` with latched mode 11.
- REQ-016 Port `three_three_row_1`, output, 1 bit: high while in `S_ROW1`.
- REQ-017 Port `three_three_reuse`, output, 1 bit: high while in `S_BODY`.
- REQ-018 Port `pass_last`, output, 1 bit: combinational pulse on the accepted last beat of any pass.
- REQ-019 Port `layer_done`, output, 1 bit: high while in `S_DONE`.
- REQ-020 Port `cfg_err`, output, 1 bit: registered one-cycle pulse on a rejected start.
- REQ-021 Port `pass_idx`, output, `CH_W` bits: current pass number.

Function
- REQ-022 The state machine SHALL have five states: `S_IDLE`, `S_ROW1`, `S_BODY`, `S_FLAT`, `S_DONE`.
- REQ-023 A beat SHALL be accepted in any active state only when `beat_ready` is 1 and `stall_4k` is 0.
- REQ-024 Counters and state transitions SHALL advance only on accepted beats; a stall cycle changes nothing.
- REQ-025 In `S_IDLE`, when `ap_start` is 1 and `ap_done` is 0, the module SHALL latch `mode`, `row_beats`, `body_beats` and `ofm_passes`; changes on these inputs after latching are ignored.
- REQ-026 On that start condition, if `mode` is 00, `body_beats` is 0, `ofm_passes` is 0 (1x1/3x3 only), or `row_beats` is 0 (3x3 only), the module SHALL pulse `cfg_err` for one cycle and remain in `S_IDLE`.
- REQ-027 On a valid start, the next state SHALL be `S_ROW1` for mode 10, otherwise `S_FLAT`.
- REQ-028 `S_ROW1` SHALL count beats 0..`row_beats`-1; on the last accepted beat, the counter clears and the state moves to `S_BODY`.
- REQ-029 `S_BODY` SHALL count beats 0..`body_beats`-1 and raise `pass_last` on the last accepted beat.
  - If `pass_idx` equals `ofm_passes`-1, the next state is `S_DONE`.
  - Otherwise `pass_idx` increments and the next state is `S_ROW1`.
- REQ-030 `S_FLAT` SHALL count beats 0..`body_beats`-1 and raise `pass_last` on the last accepted beat.
  - Maxpool uses exactly one pass; `ofm_passes` is ignored.
  - For 1x1, passes advance as in REQ-029 but the state stays in `S_FLAT` until the final pass, then moves to `S_DONE`.
- REQ-031 `S_DONE` SHALL return to `S_IDLE` when `ap_done` is 1 and `ap_start` is 0, clearing all counters and `pass_idx`.
- REQ-032 A count of 1 SHALL give a one-beat phase; the first and last beat coincide.
- REQ-033 `pass_idx` SHALL never exceed `ofm_passes`-1.
- REQ-034 Counter comparisons SHALL be width-exact (no wrap on `count - 1` for nonzero counts).

Reset
- REQ-035 While `rst` is 1, the state SHALL be `S_IDLE`, and all counters, latched configuration and `pass_idx` SHALL be 0.
- REQ-036 After reset, every output SHALL be 0 on the first clock edge.
- REQ-037 A reset asserted mid-layer SHALL abort the layer with no `pass_last` or `layer_done` pulse.
- REQ-038 Reset SHALL take priority over all other inputs.

Configuration
- REQ-039 When macro `LAYER_ADDR_SEQ_PERF_EN` is defined, the module SHALL add outputs `stall_cycles` (32 bits) and `beat_total` (32 bits):
  - `stall_cycles` counts active-state cycles in which a beat is not accepted.
  - `beat_total` counts accepted beats.
  - Both saturate at all-ones and clear on `rst` and on each valid start.
- REQ-040 When the macro is undefined, these ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
- REQ-041 Scenario 3x3: mode 10, `row_beats` 4, `body_beats` 6, `ofm_passes` 2, `beat_ready` always 1 -> state sequence ROW1 ×4, BODY ×6, ROW1 ×4, BODY ×6; `pass_last` on cycles 10 and 20; `layer_done` from cycle 21.
- REQ-042 Scenario stalls: same configuration with `stall_4k` high every third cycle and `beat_ready` low for 5 cycles -> identical beat/phase sequence, only stretched in time; with `LAYER_ADDR_SEQ_PERF_EN`, `beat_total` = 20 and `stall_cycles` equals the number of injected stall cycles.
- REQ-043 Scenario maxpool: mode 11, `body_beats` 1, `ofm_passes` 7 -> one `S_FLAT` beat with `pass_last`, then `S_DONE`; `pass_idx` stays 0.
- REQ-044 Scenario config error: mode 00, or mode 01 with `ofm_passes` 0 -> `cfg_err` pulses once, state stays `S_IDLE`, all phase outputs stay 0.
- REQ-045 Scenario mid-layer reset: mode 01, `body_beats` 8, `ofm_passes` 3, `rst` asserted at beat 13 -> outputs 0 next cycle; a new start afterwards runs 24 beats with `pass_idx` 0, 1, 2.
